ifid_idex_stage: RTL and testbench

Front-end pipeline register block for the 5-stage MIPS core: owns the PC register, the IF/ID register and the ID/EX register. It acts on the load-use hazard decision produced in ID by freezing PC and IF/ID and injecting a bubble into ID/EX. It also squashes wrong-path instructions on a taken branch/jump flush. It keeps a saturating stall counter and a sticky error flag for back-to-back stalls.

---
 rtl/ifid_idex_if.sv | 51 +++++
 rtl/ifid_idex_stage.sv | 69 ++++++
 tb/tb_ifid_idex_stage.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ifid_idex_if.sv
// Bundle of the ID-stage inputs and front-end pipeline register outputs.
// master drives the stage inputs and observes the registers; slave is the stage itself.
interface ifid_idex_if #(
    parameter int CTRL_W = 9,
    parameter int CNT_W  = 16
);
    // nop/flush are level controls sampled every rising edge; there is no
    // valid/ready handshake, ifid_valid only marks a real instruction in IF/ID.
    logic              nop;
    logic              flush;
    logic [31:0]       pc_next;
    logic [31:0]       instr_in;
    logic [CTRL_W-1:0] id_ctrl;
    logic [31:0]       id_rdata1;
    logic [31:0]       id_rdata2;
    logic [31:0]       id_imm;
    logic [4:0]        id_rs;
    logic [4:0]        id_rt;
    logic [4:0]        id_rd;

    logic [31:0]       pc;
    logic [31:0]       ifid_instr;
    logic [31:0]       ifid_pc4;
    logic              ifid_valid;
    logic [CTRL_W-1:0] idex_ctrl;
    logic [31:0]       idex_rdata1;
    logic [31:0]       idex_rdata2;
    logic [31:0]       idex_imm;
    logic [4:0]        idex_rs;
    logic [4:0]        idex_rt;
    logic [4:0]        idex_rd;
    logic [31:0]       idex_pc4;
    logic [CNT_W-1:0]  stall_cnt;
    logic              stall_err;

    modport master (
        output nop, flush, pc_next, instr_in, id_ctrl,
               id_rdata1, id_rdata2, id_imm, id_rs, id_rt, id_rd,
        input  pc, ifid_instr, ifid_pc4, ifid_valid, idex_ctrl,
               idex_rdata1, idex_rdata2, idex_imm, idex_rs, idex_rt, idex_rd,
               idex_pc4, stall_cnt, stall_err
    );

    modport slave (
        input  nop, flush, pc_next, instr_in, id_ctrl,
               id_rdata1, id_rdata2, id_imm, id_rs, id_rt, id_rd,
        output pc, ifid_instr, ifid_pc4, ifid_valid, idex_ctrl,
               idex_rdata1, idex_rdata2, idex_imm, idex_rs, idex_rt, idex_rd,
               idex_pc4, stall_cnt, stall_err
    );
endinterface

// File: rtl/ifid_idex_stage.sv
// PC, IF/ID and ID/EX registers of the 5-stage MIPS front end, with load-use
// stall/bubble, branch flush, saturating stall counter and back-to-back stall flag.
module ifid_idex_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CTRL_W   = 9,
    parameter int          CNT_W    = 16
) (
    input logic         clk,
    input logic         rst,
    ifid_idex_if.slave  bus
);
    logic prev_stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.pc          <= RESET_PC;
            bus.ifid_instr  <= '0;
            bus.ifid_pc4    <= '0;
            bus.ifid_valid  <= 1'b0;
            bus.idex_ctrl   <= '0;
            bus.idex_rdata1 <= '0;
            bus.idex_rdata2 <= '0;
            bus.idex_imm    <= '0;
            bus.idex_rs     <= '0;
            bus.idex_rt     <= '0;
            bus.idex_rd     <= '0;
            bus.idex_pc4    <= '0;
            bus.stall_cnt   <= '0;
            bus.stall_err   <= 1'b0;
            prev_stall      <= 1'b0;
        end else begin
            // ID/EX data fields advance in every non-reset case; only the
            // control bundle is zeroed to form a bubble.
            bus.idex_rdata1 <= bus.id_rdata1;
            bus.idex_rdata2 <= bus.id_rdata2;
            bus.idex_imm    <= bus.id_imm;
            bus.idex_rs     <= bus.id_rs;
            bus.idex_rt     <= bus.id_rt;
            bus.idex_rd     <= bus.id_rd;
            bus.idex_pc4    <= bus.ifid_pc4;

            if (bus.flush) begin
                bus.pc         <= bus.pc_next;
                bus.ifid_instr <= '0;
                bus.ifid_pc4   <= '0;
                bus.ifid_valid <= 1'b0;
                bus.idex_ctrl  <= '0;
                prev_stall     <= 1'b0;
            end else if (!bus.nop) begin
                // Load-use: PC and IF/ID hold, a bubble enters ID/EX.
                bus.idex_ctrl <= '0;
                if (bus.stall_cnt != {CNT_W{1'b1}}) begin
                    bus.stall_cnt <= bus.stall_cnt + CNT_W'(1);
                end
                if (prev_stall) begin
                    bus.stall_err <= 1'b1;
                end
                prev_stall <= 1'b1;
            end else begin
                bus.pc         <= bus.pc_next;
                bus.ifid_instr <= bus.instr_in;
                bus.ifid_pc4   <= bus.pc + 32'd4;
                bus.ifid_valid <= 1'b1;
                bus.idex_ctrl  <= bus.id_ctrl;
                prev_stall     <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_ifid_idex_stage.sv
// Self-checking bench for ifid_idex_stage: reference model feeds an expected queue
// checked one cycle after each drive, plus directed checks of the key scenarios.
module tb_ifid_idex_stage;
    localparam int CTRL_W = 9;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ifid_idex_if #(.CTRL_W(CTRL_W), .CNT_W(16)) bus ();
    ifid_idex_if #(.CTRL_W(CTRL_W), .CNT_W(2))  bus2 ();

    ifid_idex_stage #(.RESET_PC(32'h0), .CTRL_W(CTRL_W), .CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    ifid_idex_stage #(.RESET_PC(32'h0), .CTRL_W(CTRL_W), .CNT_W(2)) dut_sat (
        .clk (clk),
        .rst (rst),
        .bus (bus2.slave)
    );

    typedef struct packed {
        logic [31:0]       pc;
        logic [31:0]       ifid_instr;
        logic [31:0]       ifid_pc4;
        logic              ifid_valid;
        logic [CTRL_W-1:0] idex_ctrl;
        logic [31:0]       r1;
        logic [31:0]       r2;
        logic [31:0]       imm;
        logic [4:0]        rs;
        logic [4:0]        rt;
        logic [4:0]        rd;
        logic [31:0]       idex_pc4;
        logic [15:0]       cnt;
        logic              err;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // reference model state
    logic [31:0]       m_pc, m_ifid_instr, m_ifid_pc4, m_idex_pc4;
    logic              m_ifid_valid, m_prev, m_err;
    logic [CTRL_W-1:0] m_idex_ctrl;
    logic [31:0]       m_r1, m_r2, m_imm;
    logic [4:0]        m_rs, m_rt, m_rd;
    logic [15:0]       m_cnt;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_push();
        exp_t e;
        logic [31:0] old_pc;
        old_pc = m_pc;
        if (rst) begin
            m_pc = 32'h0; m_ifid_instr = '0; m_ifid_pc4 = '0; m_ifid_valid = 1'b0;
            m_idex_ctrl = '0; m_r1 = '0; m_r2 = '0; m_imm = '0;
            m_rs = '0; m_rt = '0; m_rd = '0; m_idex_pc4 = '0;
            m_cnt = '0; m_err = 1'b0; m_prev = 1'b0;
        end else begin
            m_idex_pc4 = m_ifid_pc4;
            m_r1 = bus.id_rdata1; m_r2 = bus.id_rdata2; m_imm = bus.id_imm;
            m_rs = bus.id_rs; m_rt = bus.id_rt; m_rd = bus.id_rd;
            if (bus.flush) begin
                m_pc = bus.pc_next;
                m_ifid_instr = '0; m_ifid_pc4 = '0; m_ifid_valid = 1'b0;
                m_idex_ctrl = '0;
                m_prev = 1'b0;
            end else if (!bus.nop) begin
                m_idex_ctrl = '0;
                if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
                if (m_prev) m_err = 1'b1;
                m_prev = 1'b1;
            end else begin
                m_pc = bus.pc_next;
                m_ifid_instr = bus.instr_in;
                m_ifid_pc4 = old_pc + 32'd4;
                m_ifid_valid = 1'b1;
                m_idex_ctrl = bus.id_ctrl;
                m_prev = 1'b0;
            end
        end
        e = '{m_pc, m_ifid_instr, m_ifid_pc4, m_ifid_valid, m_idex_ctrl,
              m_r1, m_r2, m_imm, m_rs, m_rt, m_rd, m_idex_pc4, m_cnt, m_err};
        exp_q.push_back(e);
    endtask

    task automatic compare_outputs();
        exp_t e;
        if (exp_q.size() == 0) begin
            check_val("queue_empty", 32'd0, 32'd1);
            return;
        end
        e = exp_q.pop_front();
        check_val("pc",          bus.pc,          e.pc);
        check_val("ifid_instr",  bus.ifid_instr,  e.ifid_instr);
        check_val("ifid_pc4",    bus.ifid_pc4,    e.ifid_pc4);
        check_val("ifid_valid",  32'(bus.ifid_valid), 32'(e.ifid_valid));
        check_val("idex_ctrl",   32'(bus.idex_ctrl),  32'(e.idex_ctrl));
        check_val("idex_rdata1", bus.idex_rdata1, e.r1);
        check_val("idex_rdata2", bus.idex_rdata2, e.r2);
        check_val("idex_imm",    bus.idex_imm,    e.imm);
        check_val("idex_rs",     32'(bus.idex_rs), 32'(e.rs));
        check_val("idex_rt",     32'(bus.idex_rt), 32'(e.rt));
        check_val("idex_rd",     32'(bus.idex_rd), 32'(e.rd));
        check_val("idex_pc4",    bus.idex_pc4,    e.idex_pc4);
        check_val("stall_cnt",   32'(bus.stall_cnt), 32'(e.cnt));
        check_val("stall_err",   32'(bus.stall_err), 32'(e.err));
    endtask

    task automatic rand_id();
        bus.id_ctrl   = CTRL_W'($urandom_range(0, 511));
        bus.id_rdata1 = $urandom;
        bus.id_rdata2 = $urandom;
        bus.id_imm    = $urandom;
        bus.id_rs     = 5'($urandom_range(0, 31));
        bus.id_rt     = 5'($urandom_range(0, 31));
        bus.id_rd     = 5'($urandom_range(0, 31));
    endtask

    task automatic cycle();
        model_push();
        @(posedge clk);
        #1;
        compare_outputs();
    endtask

    logic [31:0] instrs [4];

    initial begin
        instrs[0] = 32'h8C01_0000;
        instrs[1] = 32'h0022_1820;
        instrs[2] = 32'hAC03_0004;
        instrs[3] = 32'h1022_0003;

        bus2.nop = 1'b1; bus2.flush = 1'b0; bus2.pc_next = '0; bus2.instr_in = '0;
        bus2.id_ctrl = '0; bus2.id_rdata1 = '0; bus2.id_rdata2 = '0; bus2.id_imm = '0;
        bus2.id_rs = '0; bus2.id_rt = '0; bus2.id_rd = '0;

        // reset with random inputs
        rst = 1'b1;
        repeat (2) begin
            bus.nop = 1'($urandom_range(0, 1));
            bus.flush = 1'($urandom_range(0, 1));
            bus.pc_next = $urandom;
            bus.instr_in = $urandom;
            rand_id();
            cycle();
        end
        check_val("rst_pc", bus.pc, 32'h0);
        check_val("rst_valid", 32'(bus.ifid_valid), 32'd0);

        // straight-line flow
        rst = 1'b0;
        bus.flush = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.nop = 1'b1;
            bus.pc_next = m_pc + 32'd4;
            bus.instr_in = instrs[i];
            rand_id();
            cycle();
            check_val("seq_pc", bus.pc, 32'(4 * (i + 1)));
            check_val("seq_instr", bus.ifid_instr, instrs[i]);
            check_val("seq_pc4", bus.ifid_pc4, 32'(4 * (i + 1)));
        end

        // load-use stall then release
        bus.nop = 1'b0;
        bus.pc_next = 32'd20;
        bus.instr_in = 32'h0000_1111;
        rand_id();
        bus.id_ctrl = 9'h0F3;
        cycle();
        check_val("lu_pc", bus.pc, 32'd16);
        check_val("lu_instr", bus.ifid_instr, instrs[3]);
        check_val("lu_ctrl", 32'(bus.idex_ctrl), 32'd0);
        check_val("lu_cnt", 32'(bus.stall_cnt), 32'd1);
        bus.nop = 1'b1;
        bus.instr_in = 32'h2002_0005;
        cycle();
        check_val("rel_pc", bus.pc, 32'd20);
        check_val("rel_instr", bus.ifid_instr, 32'h2002_0005);
        check_val("rel_ctrl", 32'(bus.idex_ctrl), 32'h0F3);
        check_val("rel_err", 32'(bus.stall_err), 32'd0);

        // flush overrides hazard
        bus.flush = 1'b1;
        bus.nop = 1'b0;
        bus.pc_next = 32'h40;
        rand_id();
        cycle();
        check_val("fl_pc", bus.pc, 32'h40);
        check_val("fl_instr", bus.ifid_instr, 32'h0);
        check_val("fl_valid", 32'(bus.ifid_valid), 32'd0);
        check_val("fl_ctrl", 32'(bus.idex_ctrl), 32'd0);
        check_val("fl_cnt", 32'(bus.stall_cnt), 32'd1);

        // back-to-back hazard is sticky
        bus.flush = 1'b0;
        bus.nop = 1'b0;
        rand_id();
        cycle();
        check_val("b2b_err1", 32'(bus.stall_err), 32'd0);
        cycle();
        check_val("b2b_err2", 32'(bus.stall_err), 32'd1);
        check_val("b2b_cnt", 32'(bus.stall_cnt), 32'd3);
        bus.flush = 1'b1;
        bus.nop = 1'b1;
        bus.pc_next = 32'h80;
        cycle();
        check_val("b2b_sticky", 32'(bus.stall_err), 32'd1);

        // pc+4 wrap
        bus.flush = 1'b0;
        bus.nop = 1'b1;
        bus.pc_next = 32'hFFFF_FFFC;
        cycle();
        bus.pc_next = 32'h0;
        bus.instr_in = 32'h0000_0020;
        cycle();
        check_val("wrap_pc4", bus.ifid_pc4, 32'h0);

        // random traffic, occasional reset
        for (int i = 0; i < 200; i++) begin
            rst = ($urandom_range(0, 49) == 0);
            bus.nop = ($urandom_range(0, 3) != 0);
            bus.flush = ($urandom_range(0, 7) == 0);
            bus.pc_next = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
            bus.instr_in = $urandom;
            rand_id();
            cycle();
        end

        // reset during stall and flush
        rst = 1'b1;
        bus.nop = 1'b0;
        bus.flush = 1'b1;
        cycle();
        check_val("rst_mid_pc", bus.pc, 32'h0);
        check_val("rst_mid_cnt", 32'(bus.stall_cnt), 32'd0);
        check_val("rst_mid_err", 32'(bus.stall_err), 32'd0);

        // narrow counter saturates
        rst = 1'b0;
        bus.nop = 1'b1;
        bus.flush = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus2.nop = 1'b0;
            bus.pc_next = m_pc + 32'd4;
            cycle();
            check_val("sat_cnt", 32'(bus2.stall_cnt), (i < 3) ? 32'(i + 1) : 32'd3);
        end
        bus2.nop = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
